// File: rtl/promedio_ctrl.sv
// Temperature-average sequencer: accumulates 2**N_LOG2 samples, floors the average,
// splits it into BCD digits by repeated subtraction and holds the result for display.
module promedio_ctrl #(
  parameter int W      = 9,
  parameter int N_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         muestra_valid,
  input  logic [W-1:0] muestra,
  output logic         muestra_ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] promedio,
  output logic [3:0]   centenas,
  output logic [3:0]   decenas,
  output logic [3:0]   unidades,
  output logic         busy
);

  // state | meaning
  // ACUM  | accepting samples into acc
  // PROM  | load floor average into rem, clear digit counters
  // CEN   | subtract 100 per cycle, counting hundreds
  // DEC   | subtract 10 per cycle, counting tens; load outputs on exit
  // SAL   | result held until res_ready
  typedef enum logic [2:0] {ACUM, PROM, CEN, DEC, SAL} state_t;

  localparam int AW = W + N_LOG2;
  localparam logic [N_LOG2:0] LAST = (N_LOG2 + 1)'((2 ** N_LOG2) - 1);
  localparam logic [W-1:0] C100 = W'(100);
  localparam logic [W-1:0] C10  = W'(10);

  state_t          state, state_n;
  logic [AW-1:0]   acc;
  logic [N_LOG2:0] cnt;
  logic [W-1:0]    rem;
  logic [3:0]      cen, dec;
  logic            accept;

  assign accept        = muestra_valid && (state == ACUM);
  assign muestra_ready = (state == ACUM);
  assign res_valid     = (state == SAL);
  assign busy          = (state != ACUM);

  always_comb begin
    state_n = state;
    case (state)
      ACUM: if (accept && cnt == LAST) state_n = PROM;
      PROM: state_n = CEN;
      CEN:  if (rem < C100) state_n = DEC;
      DEC:  if (rem < C10) state_n = SAL;
      SAL:  if (res_ready) state_n = ACUM;
      default: state_n = ACUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACUM;
      acc      <= '0;
      cnt      <= '0;
      rem      <= '0;
      cen      <= '0;
      dec      <= '0;
      promedio <= '0;
      centenas <= '0;
      decenas  <= '0;
      unidades <= '0;
    end else begin
      state <= state_n;
      case (state)
        ACUM: if (accept) begin
          acc <= acc + AW'(muestra);
          cnt <= cnt + 1'b1;
        end
        PROM: begin
          rem <= acc[AW-1:N_LOG2];
          cen <= '0;
          dec <= '0;
        end
        CEN: if (rem >= C100) begin
          rem <= rem - C100;
          cen <= cen + 4'd1;
        end
        DEC: begin
          if (rem >= C10) begin
            rem <= rem - C10;
            dec <= dec + 4'd1;
          end else begin
            // acc is untouched until SAL completes, so it still holds the sum here
            promedio <= acc[AW-1:N_LOG2];
            centenas <= cen;
            decenas  <= dec;
            unidades <= rem[3:0];
          end
        end
        SAL: if (res_ready) begin
          acc <= '0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
